multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Sequencing control unit for the multicycle RV32I datapath (PC, IR, register file, ALU, unified memory).
- Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITE_BACK.
- Handles a ready-handshaked memory with wait states, traps illegal opcodes, and drives every datapath write enable and mux select.
- Replaces the state_machineUC + UC pair with a single block; ALUControl stays downstream on aluop.

Parameters:
- RESET_STATE, 4'b0000, state entered on reset (IDLE).
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching.
- stop  in  1  return to IDLE at the next instruction boundary.
- opcode  in  7  IR[6:0]; sampled only in DECODE.
- branch_taken  in  1  ALU compare result; valid in EXECUTE.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access active.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- weMem  out  1  memory write.
- weIR  out  1  IR load.
- wePc  out  1  PC load.
- weReg  out  1  register file write.
- mux_a  out  1  ALU A: 0 = rs1, 1 = PC.
- mux_b  out  2  ALU B: 0 = rs2, 1 = imm, 2 = const 4.
- mux_wb  out  2  writeback: 0 = ALU, 1 = memory data, 2 = PC+4.
- mux_pc  out  1  0 = PC+4, 1 = ALU target.
- aluop  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- state_reg  out  4  current state.
- illegal  out  1  high while in TRAP.
- cycle_cnt  out  CNT_W  performance counter (optional feature).
- instret_cnt  out  CNT_W  performance counter (optional feature).

Behaviour:
- State encoding:
  - IDLE = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, WRITE_BACK = 4, MEMORY = 5, TRAP = 6.
  - Codes 7..15 go to IDLE on the next edge.
- Registers: state_reg and opcode_q (7 bits). All outputs are combinational decode of state_reg, opcode_q, mem_ready and branch_taken.
- Reset (reset = 0, asynchronous): state_reg = IDLE, opcode_q = 0. With reset asserted, every output and counter is 0.
- Defaults in every state: all write enables 0, mem_req 0, all selects 0, aluop 00.
- IDLE: start = 1 goes to FETCH; otherwise stay.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - Wait while mem_ready = 0.
  - On mem_ready = 1: weIR = 1 in the same cycle, next state DECODE.
- DECODE:
  - opcode_q <= opcode.
  - Legal opcodes: LOAD 0000011, STORE 0100011, R 0110011, I 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111.
  - Legal opcode goes to EXECUTE; any other goes to TRAP.
- EXECUTE, by class:
  - R: mux_b = 0, aluop = 10, then WRITE_BACK.
  - I: mux_b = 1, aluop = 10, then WRITE_BACK.
  - LOAD/STORE: mux_b = 1, aluop = 00, then MEMORY.
  - BRANCH:
    - aluop = 01, mux_b = 0, wePc = 1.
    - mux_pc = branch_taken. Target is supplied by the datapath adder.
    - Next state FETCH, or IDLE if stop = 1.
  - JAL: mux_a = 1, mux_b = 1, aluop = 00, then WRITE_BACK.
  - JALR: mux_a = 0, mux_b = 1, aluop = 00, then WRITE_BACK.
- MEMORY:
  - mem_req = 1, mem_addr_sel = 1, weMem = 1 for STORE.
  - Wait while mem_ready = 0.
  - On ready:
    - LOAD goes to WRITE_BACK.
    - STORE asserts wePc = 1 (mux_pc = 0) and goes to FETCH, or IDLE if stop = 1.
- WRITE_BACK:
  - weReg = 1, wePc = 1.
  - mux_wb: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - mux_pc: 1 for JAL/JALR, 0 otherwise.
  - Next state FETCH, or IDLE if stop = 1.
- TRAP: illegal = 1, all enables 0. Only reset exits.
- Invariants:
  - wePc is high exactly one cycle per retired instruction.
  - weReg and weMem are never high in the same cycle.
  - The IR is never written outside FETCH.
- Minimum latency, no wait states:
  - BRANCH 3 cycles.
  - R, I, STORE, JAL, JALR 4 cycles.
  - LOAD 5 cycles.
  - Each memory wait cycle adds 1.
- stop is checked only at instruction boundaries. It never aborts an access in progress.
- start is ignored outside IDLE.
- Reset asserted mid-access drops mem_req immediately; the memory must tolerate an abandoned request.

Optional Feature:
- Macro: MCTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle state_reg != IDLE.
  - instret_cnt increments every cycle wePc = 1.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package mctrl_pkg holds:
  - state encodings and opcode constants;
  - mux select constants (MUXB_RS2/IMM/FOUR, WB_ALU/MEM/PC4);
  - aluop codes (also consumed by ALUControl).
- One natural sub-module, mctrl_decode: combinational map of {state_reg, opcode_q, mem_ready, branch_taken} to the control word.
- Top block holds only the registers and next-state logic.

Test Plan:
- Reset, then start = 1, mem_ready tied 1, R-type 0110011 → states 1,2,3,4,1; weReg and wePc high only in state 4; aluop = 10 in state 3.
- LOAD 0000011 with mem_ready held low 2 cycles in MEMORY → mem_req high 3 cycles, mem_addr_sel = 1, then WRITE_BACK with mux_wb = 1; 7 cycles total.
- BRANCH 1100011, branch_taken = 1 → wePc = 1 with mux_pc = 1 in EXECUTE, next state FETCH; repeat with branch_taken = 0 → mux_pc = 0.
- STORE 0100011 with stop = 1 asserted mid-EXECUTE → weMem = 1 in MEMORY, weReg never asserted, then IDLE; start = 0 holds IDLE.
- opcode 1111111 → TRAP after DECODE, illegal = 1, no enables for 20 cycles; reset = 0 → IDLE with outputs 0 asynchronously, before the next clock edge.
- With MCTRL_PERF_CNT_EN: 3 back-to-back R-type instructions → cycle_cnt = 12, instret_cnt = 3; without the macro both read 0.

Source files
------------

// File: rtl/mctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mctrl_pkg
// Purpose  : Shared encodings for the multicycle RV32I control unit: state
//            codes, opcode classes, datapath mux selects and ALU op codes.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_EXECUTE    = 4'd3,
    S_WRITE_BACK = 4'd4,
    S_MEMORY     = 4'd5,
    S_TRAP       = 4'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] MUXB_RS2  = 2'd0;
  localparam logic [1:0] MUXB_IMM  = 2'd1;
  localparam logic [1:0] MUXB_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Also consumed by the downstream ALUControl block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_addr_sel;
    logic       we_mem;
    logic       we_ir;
    logic       we_pc;
    logic       we_reg;
    logic       mux_a;
    logic [1:0] mux_b;
    logic [1:0] mux_wb;
    logic       mux_pc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mctrl_if
// Purpose  : Bundle between the control unit (master) and the datapath /
//            memory side (slave): status inputs and the full control word.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface mctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             stop;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;

  logic             mem_req;
  logic             mem_addr_sel;
  logic             weMem;
  logic             weIR;
  logic             wePc;
  logic             weReg;
  logic             mux_a;
  logic [1:0]       mux_b;
  logic [1:0]       mux_wb;
  logic             mux_pc;
  logic [1:0]       aluop;
  logic [3:0]       state_reg;
  logic             illegal;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  start, stop, opcode, branch_taken, mem_ready,
    output mem_req, mem_addr_sel, weMem, weIR, wePc, weReg, mux_a, mux_b,
           mux_wb, mux_pc, aluop, state_reg, illegal, cycle_cnt, instret_cnt
  );

  modport slave (
    output start, stop, opcode, branch_taken, mem_ready,
    input  mem_req, mem_addr_sel, weMem, weIR, wePc, weReg, mux_a, mux_b,
           mux_wb, mux_pc, aluop, state_reg, illegal, cycle_cnt, instret_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mctrl_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mctrl_decode
// Purpose  : Pure combinational map of {state, latched opcode, mem_ready,
//            branch_taken} to the datapath control word.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module mctrl_decode
  import mctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode_q,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output ctrl_word_t cw
);

  // Everything defaults to idle/zero; each state raises only what it owns
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req      = 1'b1;
        cw.mem_addr_sel = 1'b0;
        cw.we_ir        = mem_ready;
      end
      S_EXECUTE: begin
        case (opcode_q)
          OP_R: begin
            cw.mux_b = MUXB_RS2;
            cw.aluop = ALUOP_FUNCT;
          end
          OP_I: begin
            cw.mux_b = MUXB_IMM;
            cw.aluop = ALUOP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            cw.mux_b = MUXB_IMM;
            cw.aluop = ALUOP_ADD;
          end
          OP_BRANCH: begin
            // Branch target comes from the datapath adder; ALU only compares
            cw.aluop  = ALUOP_SUB;
            cw.mux_b  = MUXB_RS2;
            cw.we_pc  = 1'b1;
            cw.mux_pc = branch_taken;
          end
          OP_JAL: begin
            cw.mux_a = 1'b1;
            cw.mux_b = MUXB_IMM;
            cw.aluop = ALUOP_ADD;
          end
          OP_JALR: begin
            cw.mux_a = 1'b0;
            cw.mux_b = MUXB_IMM;
            cw.aluop = ALUOP_ADD;
          end
          default: ;
        endcase
      end
      S_MEMORY: begin
        cw.mem_req      = 1'b1;
        cw.mem_addr_sel = 1'b1;
        cw.we_mem       = (opcode_q == OP_STORE);
        // A store retires on its memory completion, so PC advances here
        cw.we_pc        = (opcode_q == OP_STORE) && mem_ready;
      end
      S_WRITE_BACK: begin
        cw.we_reg = 1'b1;
        cw.we_pc  = 1'b1;
        case (opcode_q)
          OP_LOAD:          cw.mux_wb = WB_MEM;
          OP_JAL, OP_JALR: begin
            cw.mux_wb = WB_PC4;
            cw.mux_pc = 1'b1;
          end
          default:          cw.mux_wb = WB_ALU;
        endcase
      end
      S_TRAP: cw.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : multicycle_ctrl
// Purpose  : Sequencing control for the multicycle RV32I datapath. Holds the
//            state and latched opcode; the control word is decoded in
//            mctrl_decode. Optional performance counters are built when
//            MCTRL_PERF_CNT_EN is defined, otherwise tied to zero.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'b0000,
  parameter int         CNT_W       = 32
) (
  input  logic     clk,
  input  logic     reset,
  mctrl_if.master  bus
);

  state_t     state_reg;
  state_t     state_next;
  logic [6:0] opcode_q;
  ctrl_word_t cw;

  mctrl_decode u_decode (
    .state        (state_reg),
    .opcode_q     (opcode_q),
    .mem_ready    (bus.mem_ready),
    .branch_taken (bus.branch_taken),
    .cw           (cw)
  );

  // Next-state selection; stop is only consulted where an instruction retires
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.start) state_next = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = is_legal(bus.opcode) ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        case (opcode_q)
          OP_LOAD, OP_STORE:           state_next = S_MEMORY;
          OP_BRANCH:                   state_next = bus.stop ? S_IDLE : S_FETCH;
          OP_R, OP_I, OP_JAL, OP_JALR: state_next = S_WRITE_BACK;
          default:                     state_next = S_TRAP;
        endcase
      end
      S_MEMORY: begin
        if (bus.mem_ready) begin
          if (opcode_q == OP_LOAD) state_next = S_WRITE_BACK;
          else                     state_next = bus.stop ? S_IDLE : S_FETCH;
        end
      end
      S_WRITE_BACK: state_next = bus.stop ? S_IDLE : S_FETCH;
      S_TRAP:       state_next = S_TRAP;
      default:      state_next = S_IDLE;
    endcase
  end

  // State register and opcode latch (opcode captured only while decoding)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= state_t'(RESET_STATE);
      opcode_q  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) opcode_q <= bus.opcode;
    end
  end

  assign bus.mem_req      = cw.mem_req;
  assign bus.mem_addr_sel = cw.mem_addr_sel;
  assign bus.weMem        = cw.we_mem;
  assign bus.weIR         = cw.we_ir;
  assign bus.wePc         = cw.we_pc;
  assign bus.weReg        = cw.we_reg;
  assign bus.mux_a        = cw.mux_a;
  assign bus.mux_b        = cw.mux_b;
  assign bus.mux_wb       = cw.mux_wb;
  assign bus.mux_pc       = cw.mux_pc;
  assign bus.aluop        = cw.aluop;
  assign bus.illegal      = cw.illegal;
  assign bus.state_reg    = state_reg;

`ifdef MCTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  // Busy cycles and retired instructions (one wePc pulse per retirement)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_reg != S_IDLE) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (cw.we_pc) instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.instret_cnt = instret_cnt;
`else
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl. Instructions are
//            expanded into per-cycle expected control words from their class,
//            wait counts and stop/branch choices; unrelated inputs are random.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;
`ifdef MCTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BAD    = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       req, asel, wem, weir, wepc, wereg, muxa;
    logic [1:0] muxb, muxwb;
    logic       muxpc;
    logic [1:0] aluop;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(.RESET_STATE(4'b0000), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t             e_cur;
  bit               chk_en;
  int               vectors;
  int               miscompares;
  logic [CNT_W-1:0] m_cyc;
  logic [CNT_W-1:0] m_ins;
  bit               rec;
  int               trace[$];
  int               exp_tr[5] = '{1, 2, 3, 4, 1};
  logic [6:0]       ops[7]    = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR};

  function automatic exp_t actual();
    exp_t a;
    a.st    = bus.state_reg;
    a.req   = bus.mem_req;
    a.asel  = bus.mem_addr_sel;
    a.wem   = bus.weMem;
    a.weir  = bus.weIR;
    a.wepc  = bus.wePc;
    a.wereg = bus.weReg;
    a.muxa  = bus.mux_a;
    a.muxb  = bus.mux_b;
    a.muxwb = bus.mux_wb;
    a.muxpc = bus.mux_pc;
    a.aluop = bus.aluop;
    a.ill   = bus.illegal;
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return (op == LOAD) || (op == STORE) || (op == RTYPE) || (op == ITYPE) ||
           (op == BRANCH) || (op == JAL) || (op == JALR);
  endfunction

  // Compare process: every cycle, DUT outputs vs the expected word and the
  // counter model (busy cycles / PC writes seen so far)
  always @(negedge clk) begin
    if (!reset) begin
      m_cyc <= '0;
      m_ins <= '0;
    end
    if (chk_en) begin
      check("ctrl_word", 64'(actual()), 64'(e_cur));
      check("cycle_cnt", 64'(bus.cycle_cnt), PERF ? 64'(reset ? m_cyc : '0) : 64'd0);
      check("instret_cnt", 64'(bus.instret_cnt), PERF ? 64'(reset ? m_ins : '0) : 64'd0);
    end
    if (rec && bus.state_reg != 4'd0) trace.push_back(int'(bus.state_reg));
    if (reset) begin
      if (e_cur.st != 4'd0) m_cyc <= m_cyc + 32'd1;
      if (e_cur.wepc)       m_ins <= m_ins + 32'd1;
    end
  end

  // One clock cycle of stimulus with its expected control word
  task automatic step(input exp_t e, input logic rdy, input logic st, input logic sp,
                      input logic [6:0] op, input logic bt);
    e_cur            = e;
    bus.mem_ready    = rdy;
    bus.start        = st;
    bus.stop         = sp;
    bus.opcode       = op;
    bus.branch_taken = bt;
    @(posedge clk);
    #1;
  endtask

  // n cycles idle with start low, then one idle cycle with start high
  task automatic idle(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) step(e, rb(), 1'b0, rb(), rop(), rb());
    step(e, rb(), 1'b1, rb(), rop(), rb());
  endtask

  // Expand one instruction starting in FETCH: fw fetch waits, mw memory waits,
  // sp = stop at the retirement cycle. Illegal ops return after DECODE.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic bt, input logic sp);
    exp_t e;
    bit   is_ld, is_st, is_br, is_j;
    is_ld = (op == LOAD);
    is_st = (op == STORE);
    is_br = (op == BRANCH);
    is_j  = (op == JAL) || (op == JALR);
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.st = 4'd1; e.req = 1'b1; e.weir = (i == fw);
      step(e, 1'(i == fw), rb(), rb(), rop(), rb());
    end
    e = '0; e.st = 4'd2;
    step(e, rb(), rb(), rb(), op, rb());
    if (!legal(op)) return;
    e = '0; e.st = 4'd3;
    case (op)
      RTYPE:       e.aluop = 2'b10;
      ITYPE:       begin e.muxb = 2'd1; e.aluop = 2'b10; end
      LOAD, STORE: e.muxb = 2'd1;
      BRANCH:      begin e.aluop = 2'b01; e.wepc = 1'b1; e.muxpc = bt; end
      JAL:         begin e.muxa = 1'b1; e.muxb = 2'd1; end
      default:     e.muxb = 2'd1;
    endcase
    step(e, rb(), rb(), is_br ? sp : rb(), rop(), is_br ? bt : rb());
    if (is_br) return;
    if (is_ld || is_st) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.st = 4'd5; e.req = 1'b1; e.asel = 1'b1; e.wem = is_st;
        e.wepc = is_st && (i == mw);
        step(e, 1'(i == mw), rb(), (is_st && i == mw) ? sp : rb(), rop(), rb());
      end
      if (is_st) return;
    end
    e = '0; e.st = 4'd4; e.wereg = 1'b1; e.wepc = 1'b1;
    e.muxwb = is_ld ? 2'd1 : (is_j ? 2'd2 : 2'd0);
    e.muxpc = is_j;
    step(e, rb(), rb(), sp, rop(), rb());
  endtask

  initial begin
    exp_t e;
    logic [6:0] op;
    logic sp;
    vectors = 0; miscompares = 0; rec = 1'b0;
    e_cur = '0; chk_en = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.opcode = '0;
    bus.branch_taken = 1'b0; bus.mem_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'(bus.state_reg), 64'd0);
    reset = 1'b1;

    // Three back-to-back R-types, stop on the last
    idle(1);
    trace.delete(); rec = 1'b1;
    run_instr(RTYPE, 0, 0, 1'b0, 1'b0);
    run_instr(RTYPE, 0, 0, 1'b0, 1'b0);
    run_instr(RTYPE, 0, 0, 1'b0, 1'b1);
    rec = 1'b0;
    for (int i = 0; i < 5; i++) check("r_state_trace", 64'(trace[i]), 64'(exp_tr[i]));
    check("r3_busy_cycles", 64'(trace.size()), 64'd12);
    check("r3_cycle_cnt", 64'(bus.cycle_cnt), PERF ? 64'd12 : 64'd0);
    check("r3_instret_cnt", 64'(bus.instret_cnt), PERF ? 64'd3 : 64'd0);

    // LOAD with two memory wait states
    idle(2);
    trace.delete(); rec = 1'b1;
    run_instr(LOAD, 0, 2, 1'b0, 1'b1);
    rec = 1'b0;
    check("load_latency", 64'(trace.size()), 64'd7);

    // Branch taken then not taken
    idle(0);
    trace.delete(); rec = 1'b1;
    run_instr(BRANCH, 0, 0, 1'b1, 1'b0);
    rec = 1'b0;
    check("branch_latency", 64'(trace.size()), 64'd3);
    run_instr(BRANCH, 1, 0, 1'b0, 1'b1);

    // STORE with stop, then IDLE holds while start is low
    idle(0);
    run_instr(STORE, 0, 0, 1'b0, 1'b1);
    idle(4);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 6)];
      sp = ($urandom_range(0, 4) == 0);
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb(), sp);
      if (sp) idle($urandom_range(0, 3));
    end

    // Illegal opcode: TRAP holds for 20 cycles regardless of inputs
    run_instr(BAD, 0, 0, 1'b0, 1'b0);
    e = '0; e.st = 4'd6; e.ill = 1'b1;
    for (int i = 0; i < 20; i++) step(e, rb(), rb(), rb(), rop(), rb());
    check("trap_illegal", 64'(bus.illegal), 64'd1);

    // Asynchronous reset mid-cycle clears everything before the next edge
    chk_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_ctrl", 64'(actual()), 64'd0);
    check("async_reset_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
    e_cur = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step('0, rb(), rb(), rb(), rop(), rb());
    reset = 1'b1;
    idle(1);
    run_instr(ITYPE, 1, 0, 1'b0, 1'b1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
